// File: rtl/spi_frame_alu.sv
// Nibble ALU fed by SPI frames; each result is serialised back on MISO.
// Frames that arrive while a previous response is still pending are dropped.
module spi_frame_alu #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic       clk_arduino,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic [3:0] operando_1,
    input  logic [3:0] operando_2,
    input  logic [3:0] operador,
    input  logic       CS,
    output logic       frame_ready,
    output logic       result_valid,
    output logic [3:0] leds,
    output logic [3:0] flags,
    output logic       err,
    output logic       dropped,
    output logic       MISO
);

    localparam int WW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
    localparam logic [WW-1:0] W_LAST = WW'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_TX_WAIT,
        S_TX_SHIFT
    } state_t;

    state_t r_state, w_next;

    logic [3:0]    r_op1, r_op2, r_opc;
    logic [3:0]    r_leds, r_flags;
    logic          r_err, r_dropped, r_rv, r_miso;
    logic [7:0]    r_tx;
    logic [3:0]    r_cnt;
    logic [WW-1:0] r_wait;

    logic [3:0] w_res, w_flags;
    logic       w_err, w_c, w_v;
    logic [4:0] w_sum;
    logic [3:0] w_diff;
    logic [7:0] w_prod;

    assign w_sum  = {1'b0, r_op1} + {1'b0, r_op2};
    assign w_diff = r_op1 - r_op2;
    assign w_prod = {4'b0, r_op1} * {4'b0, r_op2};

    always_comb begin
        w_res = 4'b0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (r_opc)
            4'd0: begin
                w_res = w_sum[3:0];
                w_c   = w_sum[4];
                w_v   = (r_op1[3] == r_op2[3]) && (w_sum[3] != r_op1[3]);
            end
            4'd1: begin
                w_res = w_diff;
                w_c   = r_op1 < r_op2;
                w_v   = (r_op1[3] != r_op2[3]) && (w_diff[3] != r_op1[3]);
            end
            4'd2: w_res = r_op1 & r_op2;
            4'd3: w_res = r_op1 | r_op2;
            4'd4: w_res = r_op1 ^ r_op2;
            4'd5: begin
                w_res = {r_op1[2:0], 1'b0};
                w_c   = r_op1[3];
            end
            4'd6: begin
                w_res = {1'b0, r_op1[3:1]};
                w_c   = r_op1[0];
            end
            4'd7: begin
                w_res = w_prod[3:0];
                w_c   = |w_prod[7:4];
            end
            default: w_err = 1'b1;
        endcase
    end

    // Invalid opcodes report all-zero flags, so Z is forced low too.
    assign w_flags = w_err ? 4'b0 : {w_res[3], w_res == 4'b0, w_c, w_v};

    always_ff @(posedge clk_arduino) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (frame_valid) w_next = S_EXEC;
            S_EXEC:     w_next = S_TX_WAIT;
            S_TX_WAIT: begin
                if (!CS)                  w_next = S_TX_SHIFT;
                else if (r_wait == W_LAST) w_next = S_IDLE;
            end
            S_TX_SHIFT: if (r_cnt == 4'd8 || CS) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_arduino) begin
        if (!reset) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_opc     <= '0;
            r_leds    <= '0;
            r_flags   <= '0;
            r_err     <= 1'b0;
            r_dropped <= 1'b0;
            r_rv      <= 1'b0;
            r_miso    <= 1'b0;
            r_tx      <= '0;
            r_cnt     <= '0;
            r_wait    <= '0;
        end else begin
            r_rv   <= 1'b0;
            r_miso <= 1'b0;
            if (frame_valid && r_state != S_IDLE) r_dropped <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (frame_valid) begin
                        r_op1 <= operando_1;
                        r_op2 <= operando_2;
                        r_opc <= operador;
                    end
                end
                S_EXEC: begin
                    r_leds  <= w_res;
                    r_flags <= w_flags;
                    r_err   <= w_err;
                    r_rv    <= 1'b1;
                    r_tx    <= {w_res, w_flags};
                    r_wait  <= '0;
                end
                S_TX_WAIT: begin
                    if (!CS)                  r_cnt     <= '0;
                    else if (r_wait == W_LAST) r_dropped <= 1'b1;
                    else                      r_wait    <= r_wait + 1'b1;
                end
                S_TX_SHIFT: begin
                    // Once all 8 bits are out, one more edge returns MISO to 0.
                    if (r_cnt != 4'd8) begin
                        if (CS) begin
                            r_dropped <= 1'b1;
                        end else begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                            r_cnt  <= r_cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame_ready  = (r_state == S_IDLE);
    assign result_valid = r_rv;
    assign leds         = r_leds;
    assign flags        = r_flags;
    assign err          = r_err;
    assign dropped      = r_dropped;
    assign MISO         = r_miso;

endmodule

// File: tb/tb_spi_frame_alu.sv
// Directed bench for spi_frame_alu: vector table plus
// hand-built timeout, abort, drop and reset sequences.
module tb_spi_frame_alu;

    localparam int TO = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fv;
    logic [3:0] op1, op2, opc;
    logic       cs;
    logic       fr, rv, er, drp, miso;
    logic [3:0] leds, flags;

    int checks = 0;
    int errors = 0;

    spi_frame_alu #(.WAIT_TIMEOUT(TO)) dut (
        .clk_arduino (clk),
        .reset       (rst_n),
        .frame_valid (fv),
        .operando_1  (op1),
        .operando_2  (op2),
        .operador    (opc),
        .CS          (cs),
        .frame_ready (fr),
        .result_valid(rv),
        .leds        (leds),
        .flags       (flags),
        .err         (er),
        .dropped     (drp),
        .MISO        (miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [3:0] leds;
        logic [3:0] flags;
        logic       err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] op);
        op1 = a;
        op2 = b;
        opc = op;
        fv  = 1'b1;
        tick();
        fv  = 1'b0;
        tick();
    endtask

    logic [7:0] rx;

    initial begin
        vecs[0]  = '{4'd7,  4'd9, 4'd0,  4'b0000, 4'b0110, 1'b0};
        vecs[1]  = '{4'd3,  4'd5, 4'd1,  4'b1110, 4'b1010, 1'b0};
        vecs[2]  = '{4'd7,  4'd1, 4'd0,  4'b1000, 4'b1001, 1'b0};
        vecs[3]  = '{4'd5,  4'd4, 4'd7,  4'b0100, 4'b0010, 1'b0};
        vecs[4]  = '{4'hc,  4'ha, 4'd2,  4'b1000, 4'b1000, 1'b0};
        vecs[5]  = '{4'd0,  4'd0, 4'd3,  4'b0000, 4'b0100, 1'b0};
        vecs[6]  = '{4'hf,  4'hf, 4'd4,  4'b0000, 4'b0100, 1'b0};
        vecs[7]  = '{4'd9,  4'd0, 4'd5,  4'b0010, 4'b0010, 1'b0};
        vecs[8]  = '{4'd5,  4'd0, 4'd6,  4'b0010, 4'b0010, 1'b0};
        vecs[9]  = '{4'd8,  4'd1, 4'd1,  4'b0111, 4'b0001, 1'b0};
        vecs[10] = '{4'd0,  4'd0, 4'd1,  4'b0000, 4'b0100, 1'b0};
        vecs[11] = '{4'd8,  4'd8, 4'd0,  4'b0000, 4'b0111, 1'b0};
        vecs[12] = '{4'd3,  4'd5, 4'hc,  4'b0000, 4'b0000, 1'b1};
        vecs[13] = '{4'hf,  4'hf, 4'd7,  4'b0001, 4'b0010, 1'b0};
        vecs[14] = '{4'd1,  4'd2, 4'hf,  4'b0000, 4'b0000, 1'b1};

        rst_n = 1'b0;
        fv    = 1'b1;
        op1   = 4'd7;
        op2   = 4'd1;
        opc   = 4'd0;
        cs    = 1'b1;
        tick();
        fv = 1'b0;
        chk("rst_ready", {7'b0, fr}, 8'd1);
        chk("rst_outs", {leds, flags}, 8'h00);
        chk("rst_bits", {4'b0, rv, er, drp, miso}, 8'h00);
        tick();
        chk("rst_hold_ready", {7'b0, fr}, 8'd1);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", {7'b0, fr}, 8'd1);
        chk("rel_rv", {7'b0, rv}, 8'd0);

        for (int i = 0; i < NV; i++) begin
            op1 = vecs[i].a;
            op2 = vecs[i].b;
            opc = vecs[i].op;
            fv  = 1'b1;
            tick();
            fv = 1'b0;
            chk($sformatf("v%0d_rv_pre", i), {7'b0, rv}, 8'd0);
            chk($sformatf("v%0d_busy", i), {7'b0, fr}, 8'd0);
            tick();
            chk($sformatf("v%0d_rv", i), {7'b0, rv}, 8'd1);
            chk($sformatf("v%0d_leds", i), {4'b0, leds}, {4'b0, vecs[i].leds});
            chk($sformatf("v%0d_flags", i), {4'b0, flags}, {4'b0, vecs[i].flags});
            chk($sformatf("v%0d_err", i), {7'b0, er}, {7'b0, vecs[i].err});
            chk($sformatf("v%0d_miso_wait", i), {7'b0, miso}, 8'd0);
            cs = 1'b0;
            tick();
            chk($sformatf("v%0d_rv_end", i), {7'b0, rv}, 8'd0);
            rx = 8'h00;
            for (int b = 0; b < 8; b++) begin
                tick();
                rx = {rx[6:0], miso};
            end
            chk($sformatf("v%0d_miso", i), rx, {vecs[i].leds, vecs[i].flags});
            tick();
            cs = 1'b1;
            chk($sformatf("v%0d_idle", i), {7'b0, fr}, 8'd1);
            chk($sformatf("v%0d_miso_idle", i), {7'b0, miso}, 8'd0);
        end
        chk("loop_no_drop", {7'b0, drp}, 8'd0);

        // Response timeout with CS held high.
        do_reset();
        send(4'd7, 4'd1, 4'd0);
        for (int k = 0; k < TO - 1; k++) tick();
        chk("to_not_yet", {6'b0, fr, drp}, 8'b00);
        tick();
        chk("to_idle", {6'b0, fr, drp}, 8'b11);
        chk("to_miso", {7'b0, miso}, 8'd0);
        chk("to_leds", {leds, flags}, 8'h89);

        // CS rises after 3 bits.
        do_reset();
        send(4'd3, 4'd5, 4'd1);
        cs = 1'b0;
        tick();
        rx = 8'h00;
        for (int b = 0; b < 3; b++) begin
            tick();
            rx = {rx[6:0], miso};
        end
        chk("ab_bits", rx, 8'b111);
        cs = 1'b1;
        tick();
        chk("ab_state", {5'b0, fr, drp, miso}, 8'b110);

        // Invalid opcode, then a frame arriving in TX_WAIT.
        do_reset();
        send(4'd3, 4'd5, 4'hc);
        chk("bad_err", {3'b0, er, flags}, 8'h10);
        op1 = 4'd7;
        op2 = 4'd1;
        opc = 4'd0;
        fv  = 1'b1;
        tick();
        fv = 1'b0;
        chk("tw_drop", {7'b0, drp}, 8'd1);
        tick();
        chk("tw_keep", {3'b0, er, leds}, 8'h10);
        chk("tw_no_rv", {7'b0, rv}, 8'd0);
        chk("tw_busy", {7'b0, fr}, 8'd0);

        // Frame coinciding with return to IDLE is dropped.
        do_reset();
        send(4'd7, 4'd1, 4'd0);
        cs = 1'b0;
        for (int b = 0; b < 9; b++) tick();
        op1 = 4'd3;
        op2 = 4'd5;
        opc = 4'd1;
        fv  = 1'b1;
        tick();
        fv = 1'b0;
        cs = 1'b1;
        chk("ret_drop", {6'b0, fr, drp}, 8'b11);
        tick();
        chk("ret_no_rv", {7'b0, rv}, 8'd0);
        tick();
        chk("ret_leds", {leds, flags}, 8'h89);

        // Reset in the middle of shifting.
        do_reset();
        send(4'd3, 4'd5, 4'd1);
        cs = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_bit", {7'b0, miso}, 8'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_outs", {leds, flags}, 8'h00);
        chk("mid_bits", {4'b0, rv, er, drp, miso}, 8'h00);
        rst_n = 1'b1;
        cs = 1'b1;
        tick();
        chk("mid_ready", {7'b0, fr}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
